axis_tx_pkt_fifo: RTL and testbench

Store-and-forward packet FIFO that sits directly upstream of the AXI-to-TRN TX bridge. It feeds the bridge's s_axis_tx_* inputs. It accepts TLPs from the user/DMA side and releases a packet only once its final beat (tlast) is stored. This guarantees that trn_tsrc_rdy never drops mid-packet because of a starved source. Oversize packets fall back to cut-through so the FIFO cannot deadlock.

---
 rtl/axis_pcie_pkg.sv | 25 ++
 rtl/axis_tx_pkt_fifo_ram.sv | 31 +++
 rtl/axis_tx_pkt_fifo.sv | 138 +++++++++++++
 tb/tb_axis_tx_pkt_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pcie_pkg.sv
// Shared types and helpers for the PCIe AXI-Stream TX path.
package axis_pcie_pkg;

    localparam int TUSER_W        = 4;
    localparam int TUSER_ECRC_GEN = 0;
    localparam int TUSER_ERR_FWD  = 1;
    localparam int TUSER_STR      = 2;
    localparam int TUSER_SRC_DSC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_CUT
    } fifo_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_tx_pkt_fifo_ram.sv
// Simple dual-port RAM, 1-cycle registered read; the read register
// doubles as the FIFO output register and clears on reset.
module axis_tx_pkt_fifo_ram #(
    parameter int WIDTH = 41,
    parameter int AW    = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO with cut-through fallback for oversize
// packets. Define AXIS_TX_PKT_FIFO_STATS_EN for pkt_count/peak_level.
module axis_tx_pkt_fifo
    import axis_pcie_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int DEPTH        = 512,
    parameter int ADDR_WIDTH   = clog2(DEPTH)
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [TUSER_W-1:0]      s_axis_tuser,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [TUSER_W-1:0]      m_axis_tuser,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic                    oversize_err
`ifdef AXIS_TX_PKT_FIFO_STATS_EN
   ,output logic [15:0]             pkt_count,
    output logic [ADDR_WIDTH:0]     peak_level
`endif
);

    localparam int EW = C_DATA_WIDTH + KEEP_WIDTH + TUSER_W + 1;
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q, pkt_cnt_q;
    logic [PW-1:0] ram_cnt, fill;
    logic          out_vld_q, oversize_q;
    fifo_state_e   state_q, state_d;
    logic [EW-1:0] wr_entry, rd_entry;
    logic          full, wr_fire, wr_last, drain, rd_last;
    logic          held_last, cut_mode, rel_ok, load;

    assign ram_cnt = wr_ptr_q - rd_ptr_q;
    assign fill    = ram_cnt + PW'(out_vld_q);
    assign full    = (fill == PW'(DEPTH));

    assign s_axis_tready = !full && !user_rst;
    assign wr_fire  = s_axis_tvalid && s_axis_tready;
    assign wr_last  = wr_fire && s_axis_tlast;
    assign wr_entry = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_entry;
    assign m_axis_tvalid = out_vld_q;
    assign drain     = out_vld_q && m_axis_tready;
    assign rd_last   = drain && m_axis_tlast;
    assign held_last = out_vld_q && m_axis_tlast;
    assign cut_mode  = (state_q == ST_CUT);

    // A tlast already sitting in the output register does not release the
    // beats behind it, unless the next packet's tlast lands this very cycle.
    assign rel_ok = cut_mode
                 || (pkt_cnt_q > PW'(held_last))
                 || (rd_last && wr_last);
    assign load   = rel_ok && (ram_cnt != '0) && (!out_vld_q || m_axis_tready);

    axis_tx_pkt_fifo_ram #(
        .WIDTH (EW),
        .AW    (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (user_clk),
        .rst_i   (user_rst),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_entry),
        .re_i    (load),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rd_entry)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (full && pkt_cnt_q == '0) state_d = ST_CUT;
                else if (load)               state_d = ST_SEND;
            end
            ST_SEND: begin
                if (full && pkt_cnt_q == '0) state_d = ST_CUT;
                else if (rd_last && !load)   state_d = ST_IDLE;
            end
            ST_CUT: begin
                if (wr_last) state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            oversize_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load)    rd_ptr_q <= rd_ptr_q + 1'b1;
            pkt_cnt_q <= pkt_cnt_q + PW'(wr_last) - PW'(rd_last);
            out_vld_q <= load || (out_vld_q && !m_axis_tready);
            state_q   <= state_d;
            if (state_d == ST_CUT) oversize_q <= 1'b1;
        end
    end

    assign fill_level   = fill;
    assign oversize_err = oversize_q;

`ifdef AXIS_TX_PKT_FIFO_STATS_EN
    logic [15:0]   pkt_count_q;
    logic [PW-1:0] peak_q;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            pkt_count_q <= '0;
            peak_q      <= '0;
        end else begin
            if (rd_last)       pkt_count_q <= pkt_count_q + 16'd1;
            if (fill > peak_q) peak_q      <= fill;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_axis_tx_pkt_fifo.sv
// Scoreboard bench for axis_tx_pkt_fifo (DEPTH=16): directed packets,
// random traffic with backpressure, oversize cut-through and async reset.
module tb_axis_tx_pkt_fifo;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int EW    = DW + KW + 5;

    logic          user_clk = 1'b0;
    logic          user_rst = 1'b1;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [KW-1:0] s_tkeep  = '0;
    logic          s_tlast  = 1'b0;
    logic [3:0]    s_tuser  = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [3:0]    m_tuser;
    logic [AW:0]   fill_level;
    logic          oversize_err;
`ifdef AXIS_TX_PKT_FIFO_STATS_EN
    logic [15:0]   pkt_count;
    logic [AW:0]   peak_level;
`endif

    axis_tx_pkt_fifo #(
        .C_DATA_WIDTH (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .user_clk      (user_clk),
        .user_rst      (user_rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .fill_level    (fill_level),
        .oversize_err  (oversize_err)
`ifdef AXIS_TX_PKT_FIFO_STATS_EN
       ,.pkt_count     (pkt_count),
        .peak_level    (peak_level)
`endif
    );

    always #5 user_clk = ~user_clk;

    int cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beat queue plus entry/packet counts, updated from
    // observed handshakes only.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] in_e, out_e, held, e;
    int  model_fill = 0, model_pkts = 0, f0, p0;
    bit  model_err = 0, cutpkt = 0, out_mid = 0, have_hold = 0;
    int  tl_cyc = 0, last_out_cyc = 0;
    bit  rand_rdy = 0, rdy_force = 0;

    assign in_e  = {s_tuser, s_tlast, s_tkeep, s_tdata};
    assign out_e = {m_tuser, m_tlast, m_tkeep, m_tdata};

    initial forever begin
        @(posedge user_clk);
        #2;
        m_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : rdy_force;
    end

    always @(negedge user_clk) begin
        if (user_rst) begin
            exp_q.delete();
            model_fill = 0;
            model_pkts = 0;
            model_err  = 0;
            cutpkt     = 0;
            out_mid    = 0;
            have_hold  = 0;
        end else begin
            f0 = model_fill;
            p0 = model_pkts;
            chk("fill_level", fill_level, model_fill);
            chk("s_tready", s_tready, longint'(model_fill != DEPTH));
            chk("oversize_err", oversize_err, model_err);
            if (have_hold) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_payload", out_e, held);
            end else if (out_mid && !cutpkt) begin
                chk("pkt_gap", m_tvalid, 1);
            end
            if (m_tvalid && !cutpkt)
                chk("store_fwd", longint'(model_pkts > 0), 1);
            if (s_tvalid && s_tready) begin
                exp_q.push_back(in_e);
                model_fill++;
                if (s_tlast) begin
                    model_pkts++;
                    tl_cyc = cyc;
                end
            end
            if (m_tvalid && m_tready) begin
                chk("queue_nonempty", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_beat", out_e, e);
                end
                model_fill--;
                if (m_tlast) begin
                    model_pkts--;
                    cutpkt = 0;
                    last_out_cyc = cyc;
                end
                out_mid = !m_tlast;
            end
            if (f0 == DEPTH && p0 == 0) begin
                model_err = 1;
                cutpkt    = 1;
            end
            have_hold = m_tvalid && !m_tready;
            held      = out_e;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [3:0] u);
        int w;
        w = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        @(negedge user_clk);
        while (!s_tready && w < 1000) begin
            w++;
            @(negedge user_clk);
        end
        chk("accept_timeout", longint'(w < 1000), 1);
        @(posedge user_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_rand_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            send_beat($urandom, 4'($urandom), i == len - 1, 4'($urandom));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || fill_level != 0) && w < 3000) begin
            tick();
            w++;
        end
        chk("drain_timeout", longint'(w < 3000), 1);
    endtask

    task automatic wait_valid(output int c);
        int w;
        w = 0;
        @(negedge user_clk);
        while (!m_tvalid && w < 100) begin
            w++;
            @(negedge user_clk);
        end
        chk("valid_timeout", longint'(w < 100), 1);
        c = cyc;
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, viol, w, c5;

        #23;
        chk("rst_tready", s_tready, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_oversize", oversize_err, 0);
        chk("rst_tdata", m_tdata, 0);
        @(posedge user_clk);
        #1;
        user_rst = 1'b0;
        tick();
        chk("tready_after_rst", s_tready, 1);

        // single 4-beat packet
        rdy_force = 1;
        tick(2);
        for (int i = 0; i < 4; i++)
            send_beat(DW'(i + 1), 4'hf, i == 3, 4'(i));
        wait_valid(rise);
        chk("t1_latency", rise - tl_cyc, 2);
        wait_drain();
        chk("t1_span", last_out_cyc - rise, 3);

        // store-and-forward hold
        for (int i = 0; i < 3; i++)
            send_beat(DW'(32'h11 + i), 4'h3, 1'b0, 4'ha);
        viol = 0;
        repeat (20) begin
            @(negedge user_clk);
            if (m_tvalid) viol++;
        end
        chk("t2_hold", viol, 0);
        tick();
        send_beat(32'h14, 4'h1, 1'b1, 4'h5);
        wait_valid(rise);
        chk("t2_latency", rise - tl_cyc, 2);
        wait_drain();
        chk("t2_span", last_out_cyc - rise, 3);

        // random traffic with random backpressure
        rand_rdy = 1;
        repeat (40) send_rand_pkt($urandom_range(1, 15));
        wait_drain();
        rand_rdy = 0;
        rdy_force = 0;
        tick(2);

        // oversize packet falls back to cut-through
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send_beat(DW'(32'h400 + i), 4'hf, i == 19, 4'(i));
            end
            begin
                w = 0;
                while (fill_level != DEPTH && w < 500) begin
                    tick();
                    w++;
                end
                chk("t4_full_reached", longint'(w < 500), 1);
                @(negedge user_clk);
                chk("t4_tready_low", s_tready, 0);
                tick(4);
                chk("t4_oversize", oversize_err, 1);
                rdy_force = 1;
            end
        join
        wait_drain();
        chk("t4_sticky", oversize_err, 1);

        // tlast in and tlast out in the same cycle
        rdy_force = 0;
        tick(2);
        send_beat(32'ha0, 4'hf, 1'b0, 4'h1);
        send_beat(32'ha1, 4'hf, 1'b1, 4'h2);
        send_beat(32'hb0, 4'hf, 1'b0, 4'h3);
        send_beat(32'hb1, 4'hf, 1'b0, 4'h4);
        tick(2);
        rdy_force = 1;
        tick();
        send_beat(32'hb2, 4'hf, 1'b1, 4'h8);
        @(negedge user_clk);
        chk("t5_no_bubble", m_tvalid, 1);
        c5 = cyc;
        wait_drain();
        chk("t5_span", last_out_cyc - c5, 2);

        // async reset with a held packet and a partial one
        rdy_force = 0;
        tick(2);
        send_beat(32'hc0, 4'hf, 1'b0, 4'h0);
        send_beat(32'hc1, 4'hf, 1'b1, 4'h0);
        for (int i = 0; i < 3; i++)
            send_beat(DW'(32'hd0 + i), 4'hf, 1'b0, 4'h6);
        #2;
        user_rst = 1'b1;
        #1;
        chk("t6_tvalid", m_tvalid, 0);
        chk("t6_fill", fill_level, 0);
        chk("t6_tready", s_tready, 0);
        @(posedge user_clk);
        @(posedge user_clk);
        #3;
        user_rst = 1'b0;
        tick();
        chk("t6_oversize_clr", oversize_err, 0);
        rdy_force = 1;
        tick(2);
        send_beat(32'he0, 4'h7, 1'b0, 4'h9);
        send_beat(32'he1, 4'h1, 1'b1, 4'hc);
        wait_drain();
`ifdef AXIS_TX_PKT_FIFO_STATS_EN
        chk("t6_pkt_count", pkt_count, 1);
        chk("t6_peak_level", peak_level, 2);
`endif
        tick(4);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
